// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Bytes per instruction word; the fetch PC advances by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Small FIFO of fetched {pc, instr} pairs that absorbs decode backpressure.
// Push and pop may happen in the same cycle; flush empties it and wins over both.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  output logic [OCC_W-1:0]   occ_o,
  output fetch_entry_t       head_o
);

  fetch_entry_t          store_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Pointer increment that wraps at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Qualify requests: never pop when empty, never push into a full buffer
  // unless a pop frees a slot in the same cycle; flush suppresses both.
  always_comb begin
    do_pop_s  = pop_i && !flush_i && (occ_q != {OCC_W{1'b0}});
    do_push_s = push_i && !flush_i && ((occ_q != OCC_W'(DEPTH)) || do_pop_s);
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      store_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = store_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, tracks the single in-flight read of a
// 1-cycle-latency instruction memory and hands {pc, instr} to decode.
// A returning word bypasses straight to the output when the skid buffer is
// empty; otherwise it queues behind older words to keep program order.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      fetch_pc_q;
  logic [31:0]      fetch_pc_d;
  logic             inflight_v_q;
  logic [31:0]      inflight_pc_q;

  logic [OCC_W-1:0] occ_s;
  fetch_entry_t     head_s;
  fetch_entry_t     ret_entry_s;
  logic             buf_empty_s;
  logic             out_fire_s;
  logic [OCC_W:0]   load_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;

  // Output select: buffer head first, then the word returning this cycle.
  always_comb begin
    buf_empty_s       = (occ_s == {OCC_W{1'b0}});
    ret_entry_s.pc    = inflight_pc_q;
    ret_entry_s.instr = mem_rdata;
    out_valid         = 1'b0;
    out_pc            = 32'h0000_0000;
    out_instr         = 32'h0000_0000;
    if (!buf_empty_s) begin
      out_valid = 1'b1;
      out_pc    = head_s.pc;
      out_instr = head_s.instr;
    end else if (inflight_v_q) begin
      out_valid = 1'b1;
      out_pc    = inflight_pc_q;
      out_instr = mem_rdata;
    end else begin
      out_valid = 1'b0;
    end
  end

  // Issue and buffer control. A new read is only issued when its return is
  // guaranteed a slot: either room remains after counting the in-flight word,
  // or decode frees a slot this cycle. Redirect squashes everything.
  always_comb begin
    out_fire_s = out_valid && out_ready;
    load_s     = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_v_q};
    issue_s    = fetch_en && !redirect_valid &&
                 ((load_s < (OCC_W + 1)'(BUF_DEPTH)) || out_fire_s);
    push_s     = inflight_v_q && !redirect_valid && (!buf_empty_s || !out_fire_s);
    pop_s      = out_fire_s && !buf_empty_s && !redirect_valid;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_v_q <= issue_s;
      if (issue_s) begin
        inflight_pc_q <= fetch_pc_q;
      end
    end
  end

  fetch_skid_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push_s),
    .push_data_i (ret_entry_s),
    .pop_i       (pop_s),
    .occ_o       (occ_s),
    .head_o      (head_s)
  );

  assign mem_addr = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl. Instance A uses the default reset
// PC and carries the main stream; instance B starts near the top of the
// address space to exercise PC wrap.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] MASK     = 32'hA5A5_0000;
  localparam logic [31:0] PC_A     = 32'h0000_0000;
  localparam logic [31:0] PC_B     = 32'hFFFF_FFF8;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        rst_n_a;
  logic        rst_n_b;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] mem_addr_a,  mem_rdata_a,  out_pc_a,  out_instr_a;
  logic        out_valid_a;
  logic [31:0] mem_addr_b,  mem_rdata_b,  out_pc_b,  out_instr_b;
  logic        out_valid_b;

  int checks;
  int errors;
  int fires;
  logic [31:0] exp_q [$];

  instr_fetch_ctrl #(.RESET_PC(PC_A), .BUF_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_instr(out_instr_a)
  );

  instr_fetch_ctrl #(.RESET_PC(PC_B), .BUF_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_instr(out_instr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory models.
  always @(posedge clk) begin
    mem_rdata_a <= mem_addr_a ^ MASK;
    mem_rdata_b <= mem_addr_b ^ MASK;
  end

  // Scoreboard for instance A: reset and redirect reseed the expected PC
  // stream; every decode-side fire pops and compares the oldest entry.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] tgt;
    if (!rst_n_a) begin
      exp_q.delete();
      for (int i = 0; i < 256; i++) exp_q.push_back(PC_A + 32'(4 * i));
    end else begin
      if (out_valid_a && out_ready) begin
        checks++;
        fires++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got pc %h with nothing expected", out_pc_a);
        end else begin
          e = exp_q.pop_front();
          if (out_pc_a !== e || out_instr_a !== (e ^ MASK)) begin
            errors++;
            $display("FAIL sb_stream: got pc %h instr %h, expected pc %h instr %h",
                     out_pc_a, out_instr_a, e, e ^ MASK);
          end
        end
      end
      if (redirect_valid) begin
        tgt = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(tgt + 32'(4 * i));
      end
    end
  end

  // Occupancy plus in-flight read must never exceed the buffer depth.
  always @(negedge clk) begin
    if (rst_n_a) begin
      checks++;
      if (int'(dut_a.occ_s) + int'(dut_a.inflight_v_q) > int'(DEPTH)) begin
        errors++;
        $display("FAIL occ_invariant: occ %0d inflight %0d depth %0d",
                 dut_a.occ_s, dut_a.inflight_v_q, DEPTH);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || out_pc_a !== 32'h0 || out_instr_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid %b pc %h instr %h, expected 0 0 0",
               out_valid_a, out_pc_a, out_instr_a);
    end
    checks++;
    if (mem_addr_a !== PC_A) begin
      errors++;
      $display("FAIL reset_mem_addr: got %h expected %h", mem_addr_a, PC_A);
    end
    @(posedge clk); #2 rst_n_a = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: valid %b expected 0", out_valid_a);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_pc_a !== 32'(4 * i)) begin
        errors++;
        $display("FAIL reset_first_words: valid %b pc %h, expected 1 %h",
                 out_valid_a, out_pc_a, 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [3];
    seq[0] = 32'h8; seq[1] = 32'hC; seq[2] = 32'h10;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_pc_a !== 32'h8) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid %b pc %h, expected 1 00000008",
                 i, out_valid_a, out_pc_a);
      end
      if (i >= 1) begin
        checks++;
        if (mem_addr_a !== 32'h10) begin
          errors++;
          $display("FAIL bp_stall_addr: cycle %0d mem_addr %h expected 00000010",
                   i, mem_addr_a);
        end
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_pc_a !== seq[i]) begin
        errors++;
        $display("FAIL bp_drain: step %0d valid %b pc %h, expected 1 %h",
                 i, out_valid_a, out_pc_a, seq[i]);
      end
    end
  endtask

  task automatic test_redirect();
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    out_ready      = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_a.occ_s !== 2'd2 || out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL redir_setup: occ %0d valid %b, expected 2 1", dut_a.occ_s, out_valid_a);
    end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || mem_addr_a !== 32'h100) begin
      errors++;
      $display("FAIL redir_t1: valid %b mem_addr %h, expected 0 00000100",
               out_valid_a, mem_addr_a);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_pc_a !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL redir_target: step %0d valid %b pc %h, expected 1 %h",
                 i, out_valid_a, out_pc_a, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_fetch_en();
    int n_fire;
    n_fire = 0;
    @(posedge clk); #1 fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid_a && out_ready) n_fire++;
      if (i >= 1) begin
        checks++;
        if (out_valid_a !== 1'b0) begin
          errors++;
          $display("FAIL fe_drain: cycle %0d valid %b expected 0", i, out_valid_a);
        end
      end
    end
    checks++;
    if (n_fire > 1) begin
      errors++;
      $display("FAIL fe_count: delivered %0d words, expected at most 1", n_fire);
    end
    @(posedge clk); #1 fetch_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_a.occ_s !== 2'd2 || out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL ar_full: occ %0d valid %b, expected 2 1", dut_a.occ_s, out_valid_a);
    end
    @(posedge clk); #2 rst_n_a = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || mem_addr_a !== PC_A) begin
      errors++;
      $display("FAIL ar_immediate: valid %b mem_addr %h, expected 0 %h",
               out_valid_a, mem_addr_a, PC_A);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n_a = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_pc_a !== PC_A + 32'(4 * i)) begin
        errors++;
        $display("FAIL ar_restart: step %0d valid %b pc %h, expected 1 %h",
                 i, out_valid_a, out_pc_a, PC_A + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    checks++;
    if (mem_addr_b !== PC_B) begin
      errors++;
      $display("FAIL wrap_reset_addr: got %h expected %h", mem_addr_b, PC_B);
    end
    @(posedge clk); #2 rst_n_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = PC_B + 32'(4 * i);
      checks++;
      if (out_valid_b !== 1'b1 || out_pc_b !== e || out_instr_b !== (e ^ MASK)) begin
        errors++;
        $display("FAIL wrap_seq: step %0d valid %b pc %h instr %h, expected 1 %h %h",
                 i, out_valid_b, out_pc_b, out_instr_b, e, e ^ MASK);
      end
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    fires          = 0;
    rst_n_a        = 1'b0;
    rst_n_b        = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    test_reset();
    test_backpressure();
    test_redirect();
    test_fetch_en();
    test_async_reset();
    test_wrap();

    repeat (2) @(negedge clk);
    checks++;
    if (fires < 15) begin
      errors++;
      $display("FAIL total_fires: got %0d expected at least 15", fires);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
